daq_sample_capture: RTL and testbench

Receive-side companion to the DAQ read-clock generator: captures ADC parallel data on each read-clock pulse and tags it by channel. One frame of `NCH` channels is read per conversion, and each sample is pushed into a small FIFO with a valid/ready stream output. The block sits between the ADC pins (already synchronised) and the USB/packetiser path. It also produces the enable that gates the read-clock generator.

---
 rtl/daq_pkg.sv | 26 ++
 rtl/daq_sync_fifo.sv | 56 +++++
 rtl/daq_sample_capture.sv | 155 +++++++++++++++
 tb/tb_daq_sample_capture.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/daq_pkg.sv
`default_nettype none
// ============================================================================
// Package : daq_pkg
// Desc    : Shared types for the DAQ sample-capture path.
// Rev     : 1.0 - initial release
// ============================================================================
package daq_pkg;

  localparam int c_DAQ_DW  = 16;
  localparam int c_DAQ_NCH = 8;
  localparam int c_DAQ_CW  = $clog2(c_DAQ_NCH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                last;
    logic [c_DAQ_CW-1:0] chan;
    logic [c_DAQ_DW-1:0] data;
  } frame_word_t;

endpackage
`default_nettype wire

// File: rtl/daq_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : daq_sync_fifo
// Desc   : Single-clock register-array FIFO; a push into a full FIFO is taken
//          only when a pop happens in the same cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module daq_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             empty_o
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == (c_AW+1)'(DEPTH));
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
      r_count <= r_count + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data_i;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign pop_data_o = empty_o ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/daq_sample_capture.sv
`default_nettype none
// ============================================================================
// Module : daq_sample_capture
// Desc   : Captures one NCH-channel ADC frame per conversion into a tagged FIFO.
// Rev    : 1.0 - initial release
// ============================================================================
module daq_sample_capture
  import daq_pkg::*;
#(
  parameter int DW     = c_DAQ_DW,
  parameter int NCH    = c_DAQ_NCH,
  parameter int SETTLE = 1,
  parameter int DEPTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic                   busy_i,
  input  logic                   rdclk_i,
  input  logic [DW-1:0]          data_i,
  output logic                   rd_en_o,
  output logic [DW-1:0]          m_data_o,
  output logic [$clog2(NCH)-1:0] m_chan_o,
  output logic                   m_last_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   frame_done_o,
  output logic                   overflow_o,
  input  logic                   clear_i
);

  localparam int              c_CW        = $clog2(NCH);
  localparam int              c_FW        = 1 + c_CW + DW;
  localparam logic [c_CW-1:0] c_LAST_CHAN = c_CW'(NCH - 1);

  typedef struct packed {
    logic            last;
    logic [c_CW-1:0] chan;
    logic [DW-1:0]   data;
  } word_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_busy_q;
  logic            r_rdclk_q;
  logic [c_CW-1:0] r_chan;
  logic [1:0]      r_settle_cnt;
  logic            r_settle_act;
  logic            r_overflow;

  logic  w_busy_fall;
  logic  w_edge_take;
  logic  w_sample;
  logic  w_chan_last;
  logic  w_full;
  logic  w_empty;
  logic  w_pop;
  logic  w_drop;
  word_t w_push_word;
  word_t w_head;

  assign w_busy_fall = r_busy_q && !busy_i;
  assign w_edge_take = (r_state == ST_READ) && !r_rdclk_q && rdclk_i && !r_settle_act;
  assign w_chan_last = (r_chan == c_LAST_CHAN);

  // With SETTLE=0 the edge cycle itself is the sample cycle.
  assign w_sample = (r_state == ST_READ) &&
                    ((SETTLE == 0) ? w_edge_take : (r_settle_act && r_settle_cnt == 2'd1));

  assign w_pop  = m_valid_o && m_ready_i;
  assign w_drop = w_sample && w_full && !w_pop;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_busy_q  <= 1'b0;
      r_rdclk_q <= 1'b0;
    end else begin
      r_busy_q  <= busy_i;
      r_rdclk_q <= rdclk_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_settle_cnt <= 2'd0;
      r_settle_act <= 1'b0;
    end else if (r_settle_act) begin
      r_settle_cnt <= r_settle_cnt - 2'd1;
      if (r_settle_cnt == 2'd1) r_settle_act <= 1'b0;
    end else if (w_edge_take && SETTLE != 0) begin
      r_settle_cnt <= 2'(SETTLE);
      r_settle_act <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_busy_fall && en_i)       w_state_nxt = ST_READ;
      ST_READ: if (w_sample && w_chan_last)   w_state_nxt = ST_DONE;
      ST_DONE:                                w_state_nxt = ST_IDLE;
      default:                                w_state_nxt = ST_IDLE;
    endcase
  end

  // Channel advances on every sample, dropped or not, to keep frame alignment.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_chan <= '0;
    end else if (r_state == ST_IDLE && w_busy_fall && en_i) begin
      r_chan <= '0;
    end else if (w_sample && !w_chan_last) begin
      r_chan <= r_chan + c_CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (clear_i) r_overflow <= 1'b0;
  end

  assign w_push_word.last = w_chan_last;
  assign w_push_word.chan = r_chan;
  assign w_push_word.data = data_i;

  daq_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (c_FW)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .push_i      (w_sample),
    .push_data_i (w_push_word),
    .full_o      (w_full),
    .pop_i       (m_ready_i),
    .pop_data_o  (w_head),
    .empty_o     (w_empty)
  );

  assign rd_en_o      = (r_state == ST_READ);
  assign frame_done_o = (r_state == ST_DONE);
  assign overflow_o   = r_overflow;
  assign m_valid_o    = !w_empty;
  assign m_last_o     = w_head.last;
  assign m_chan_o     = w_head.chan;
  assign m_data_o     = w_head.data;

endmodule
`default_nettype wire

// File: tb/tb_daq_sample_capture.sv
`default_nettype none
// ============================================================================
// Module : tb_daq_sample_capture
// Desc   : Randomised scoreboard bench for daq_sample_capture.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_daq_sample_capture;
  import daq_pkg::*;

  localparam int DW     = 16;
  localparam int NCH    = 8;
  localparam int SETTLE = 2;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(NCH);
  localparam int SPACING = 6;

  logic          clk_i     = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          en_i      = 1'b0;
  logic          busy_i    = 1'b0;
  logic          rdclk_i   = 1'b0;
  logic          m_ready_i = 1'b0;
  logic          clear_i   = 1'b0;
  logic [DW-1:0] data_i    = '0;
  logic          rd_en_o, m_last_o, m_valid_o, frame_done_o, overflow_o;
  logic [DW-1:0] m_data_o;
  logic [CW-1:0] m_chan_o;

  int n_cmp = 0;
  int n_err = 0;

  // ev_q: samples the stimulus has presented this cycle; sb_q: model FIFO contents
  frame_word_t ev_q[$];
  frame_word_t sb_q[$];
  bit mon_en   = 1'b0;
  bit exp_ovf  = 1'b0;
  bit exp_done = 1'b0;

  always #5 clk_i = ~clk_i;

  daq_sample_capture #(
    .DW(DW), .NCH(NCH), .SETTLE(SETTLE), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .busy_i(busy_i),
    .rdclk_i(rdclk_i), .data_i(data_i), .rd_en_o(rd_en_o),
    .m_data_o(m_data_o), .m_chan_o(m_chan_o), .m_last_o(m_last_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .frame_done_o(frame_done_o),
    .overflow_o(overflow_o), .clear_i(clear_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: output flags, pops against the model FIFO, then this cycle's pushes.
  always @(negedge clk_i) begin
    frame_word_t e;
    frame_word_t h;
    bit drop;
    if (mon_en) begin
      chk("overflow_o", 32'(overflow_o), 32'(exp_ovf));
      chk("frame_done_o", 32'(frame_done_o), 32'(exp_done));
      chk("m_valid_o", 32'(m_valid_o), 32'(sb_q.size() != 0));
      if (m_valid_o && m_ready_i && sb_q.size() != 0) begin
        h = sb_q.pop_front();
        chk("m_data_o", 32'(m_data_o), 32'(h.data));
        chk("m_chan_o", 32'(m_chan_o), 32'(h.chan));
        chk("m_last_o", 32'(m_last_o), 32'(h.last));
      end
      drop     = 1'b0;
      exp_done = 1'b0;
      while (ev_q.size() != 0) begin
        e = ev_q.pop_front();
        if (sb_q.size() < DEPTH) sb_q.push_back(e);
        else                     drop = 1'b1;
        if (e.last) exp_done = 1'b1;
      end
      if (drop)         exp_ovf = 1'b1;
      else if (clear_i) exp_ovf = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    data_i = DW'($urandom);
  endtask

  // 0: always ready, 1: random, 2: never, 3: only in the sample cycle
  task automatic set_ready(input int mode, input int k);
    case (mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'($urandom_range(0, 1));
      2:       m_ready_i = 1'b0;
      default: m_ready_i = (k == SETTLE);
    endcase
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " rd_en_o"},      32'(rd_en_o), 0);
    chk({tag, " m_valid_o"},    32'(m_valid_o), 0);
    chk({tag, " m_data_o"},     32'(m_data_o), 0);
    chk({tag, " m_chan_o"},     32'(m_chan_o), 0);
    chk({tag, " m_last_o"},     32'(m_last_o), 0);
    chk({tag, " frame_done_o"}, 32'(frame_done_o), 0);
    chk({tag, " overflow_o"},   32'(overflow_o), 0);
  endtask

  // One conversion: busy fall, then NCH read-clock pulses SPACING cycles apart.
  task automatic run_frame(input bit glitch, input bit en_drop, input int rmode,
                           input int abort_chan);
    tick(); busy_i = 1'b1; en_i = 1'b1; set_ready(rmode, -1);
    tick(); busy_i = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < SPACING; k++) begin
        tick();
        rdclk_i = glitch ? (k == 0 || k == 2) : (k < 2);
        set_ready(rmode, k);
        if (glitch && c == 4) busy_i = (k == 1);
        if (en_drop && c >= 2) en_i = 1'b0;
        if (c == abort_chan && k == 1) begin
          #2;
          reset_n_i = 1'b0;
          mon_en    = 1'b0;
          #1;
          check_outputs_zero("mid-frame reset");
          sb_q.delete();
          ev_q.delete();
          exp_ovf  = 1'b0;
          exp_done = 1'b0;
          rdclk_i  = 1'b0;
          return;
        end
        if (k == SETTLE)
          ev_q.push_back('{last: (c == NCH - 1), chan: CW'(c), data: data_i});
        @(negedge clk_i);
        if (c == 0 && k == 0)                chk("rd_en_o at frame start", 32'(rd_en_o), 1);
        if (c == NCH - 1 && k == SETTLE)     chk("rd_en_o at last sample", 32'(rd_en_o), 1);
        if (c == NCH - 1 && k == SETTLE + 1) chk("rd_en_o after frame", 32'(rd_en_o), 0);
      end
    end
    rdclk_i = 1'b0;
    en_i    = 1'b1;
    tick();
  endtask

  task automatic drain();
    int i;
    m_ready_i = 1'b1;
    rdclk_i   = 1'b0;
    i = 0;
    while (i < 100 && sb_q.size() != 0) begin
      tick();
      i++;
    end
    tick();
    chk("drain completes", 32'(sb_q.size()), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check_outputs_zero("reset");
    reset_n_i = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;

    run_frame(1'b0, 1'b0, 0, -1);
    repeat (2) run_frame(1'b0, 1'b0, 1, -1);
    drain();

    // busy fall in READ, edge inside settle window, en_i dropped mid-frame
    run_frame(1'b1, 1'b1, 0, -1);
    drain();

    // busy fall with capture disabled must not start a frame
    tick(); busy_i = 1'b1; en_i = 1'b0;
    tick(); busy_i = 1'b0;
    for (int k = 0; k < 2 * SPACING; k++) begin
      tick();
      rdclk_i = ((k % SPACING) < 2);
      @(negedge clk_i);
      if (k == 1) chk("rd_en_o with en_i=0", 32'(rd_en_o), 0);
    end
    rdclk_i = 1'b0;
    en_i    = 1'b1;

    // overflow: FIFO keeps chans 0..3, remainder dropped
    run_frame(1'b0, 1'b0, 2, -1);
    tick(); clear_i = 1'b1;
    tick(); clear_i = 1'b0;
    // full FIFO with push and pop together every sample
    run_frame(1'b0, 1'b0, 3, -1);
    // drops while clear_i is held
    clear_i = 1'b1;
    run_frame(1'b0, 1'b0, 2, -1);
    clear_i = 1'b0;
    drain();

    // reset at chan 3, then a clean frame from chan 0
    run_frame(1'b0, 1'b0, 0, 3);
    busy_i = 1'b0;
    en_i   = 1'b1;
    repeat (2) tick();
    reset_n_i = 1'b1;
    repeat (2) tick();
    mon_en = 1'b1;
    run_frame(1'b0, 1'b0, 1, -1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
